uart_tx_serializer: RTL and testbench
=====================================

# uart_tx_serializer

Serial transmit engine for the PL011-style UART. It accepts bytes over the same byte/strobe interface the register model uses for `char_out_to_tbx`/`output_strobe`, buffers them in a FIFO, and serializes each one onto `TXD`. Frame format, divisor, break and flow control come from the register model's `LCR_H`/`IBRD`/`CR` fields.

## Interface
- `FIFO_DEPTH`, default 16: transmit FIFO entries; power of 2, minimum 2.
- `CLK` input 1: single clock for the whole block.
- `RST` input 1: synchronous, active-high reset.
- `DATA_IN` input 8: byte to enqueue.
- `DATA_STROBE` input 1: one-cycle enqueue pulse.
- `FULL` output 1: FIFO holds `FIFO_DEPTH` entries.
- `EMPTY` output 1: FIFO holds 0 entries.
- `LEVEL` output clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `OVERRUN` output 1: one-cycle pulse when a strobe is dropped.
- `DIVISOR` input 16: CLK cycles per bit; 0 is treated as 1.
- `WLEN` input 2: data bits = WLEN+5.
- `PEN`, `EPS`, `SPS`, `STP2`, `BRK` input 1 each: parity enable, even parity select, stick parity, two stop bits, send break.
- `TXE` input 1: transmit enable.
- `CTSEN` input 1: CTS flow-control enable.
- `CTS` input 1: clear to send, active high.
- `TXD` output 1: serial line; idle high.
- `BUSY` output 1: a frame is in progress.

## Operation
- FIFO:
  - A strobe with `FULL`=0 writes `DATA_IN`.
  - A strobe with `FULL`=1 drops the byte and pulses `OVERRUN` the next cycle. This holds even if a pop happens in the same cycle.
  - A write and a pop in the same cycle leave `LEVEL` unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- Start condition: `EMPTY`=0 and `TXE`=1 and (`CTSEN`=0 or `CTS`=1).
- States: `IDLE`, `START`, `DATA`, `PARITY`, `STOP`.
  - `IDLE` → `START` when the start condition holds. Pop the head byte into the shift register and latch `WLEN`, `PEN`, `EPS`, `SPS`, `STP2` and the effective divisor. Configuration changes mid-frame have no effect on that frame.
  - `START` → `DATA` after one bit period, with `TXD`=0.
  - `DATA` shifts LSB first for WLEN+5 bit periods, then goes to `PARITY` if PEN=1, else to `STOP`.
  - `PARITY` lasts one bit period. Parity bit value:
    - SPS=1: ~EPS.
    - SPS=0, EPS=1: XOR of the data bits.
    - SPS=0, EPS=0: ~XOR of the data bits.
  - `STOP` drives `TXD`=1 for 1 bit period, or 2 if STP2=1. At its final cycle:
    - start condition true → go directly to `START`, with no idle gap.
    - otherwise → `IDLE`.
- Bit period: a down-counter loads divisor−1 on entering each bit and advances when it reaches 0. Each bit therefore lasts exactly `DIVISOR` cycles (1 if `DIVISOR`=0).
- Flow control and enable:
  - `TXE`=0, or `CTS` low while `CTSEN`=1, only blocks new frames.
  - A frame in progress always completes.
- `BRK`=1 forces `TXD`=0 combinationally-registered (next cycle) regardless of state. The state machine keeps running and timing is unaffected.
- `BUSY`=1 in every state except `IDLE`.
- `RST` asserted at any time, including mid-frame:
  - FIFO empties.
  - State returns to `IDLE`.
  - Frame in progress is abandoned.

## Timing
- Reset values (from the cycle after `RST` is sampled high): `TXD`=1, `BUSY`=0, `FULL`=0, `EMPTY`=1, `LEVEL`=0, `OVERRUN`=0.
- `TXD`, `BUSY`, `FULL`, `EMPTY`, `LEVEL` and `OVERRUN` are all registered.
- Latency from a strobe in cycle W into an empty FIFO, with the block idle and enabled:
  - `EMPTY`=0 and `LEVEL`=1 at W+1.
  - Start bit (`TXD`=0) and `BUSY`=1 from W+2.
  - `LEVEL` returns to 0 at W+2.
- Frame length = divisor × (1 + WLEN+5 + PEN + 1 + STP2) cycles.
- With the start condition held, back-to-back frames are contiguous: the next start bit immediately follows the last stop cycle.
- Start-condition changes (for example `CTS` rising) are seen in `IDLE`. The start bit follows 1 cycle later.

## Test plan
- `DIVISOR`=4, WLEN=3, PEN=0, STP2=0; strobe 0x55 at cycle 0.
  - `TXD`=0 for cycles 2–5.
  - Data 1,0,1,0,1,0,1,0, each 4 cycles.
  - Stop bit high for cycles 38–41.
  - `BUSY` high for cycles 2–41, then low.
- `DIVISOR`=2, WLEN=2, PEN=1, EPS=1; strobe 0x41 → data 1,0,0,0,0,0,1, then parity 0, then stop.
- Same setup with EPS=0 → parity 1. With SPS=1, EPS=1 → parity 0.
- Overrun and drain: `TXE`=0; 17 strobes of 0x00..0x10.
  - `LEVEL`=16, `FULL`=1.
  - `OVERRUN` pulses once, after the 17th strobe.
  - Then set `TXE`=1: 16 contiguous frames (0x00..0x0F), no `TXD` high gap beyond the stop bits, `EMPTY`=1 after the last pop.
- Flow control: `CTSEN`=1, `CTS`=0; strobe 0xA5.
  - `TXD` stays high for 100 cycles.
  - Raise `CTS` at cycle T → start bit at T+1.
  - Dropping `CTS` mid-frame does not stop that frame.
- Break and reset:
  - `BRK`=1 mid-frame → `TXD`=0 from the next cycle; `BUSY` falls at the normal frame end.
  - `RST` mid-frame with `LEVEL`=3 → next cycle `TXD`=1, `BUSY`=0, `LEVEL`=0, `EMPTY`=1.
  - `DIVISOR`=0 → each bit lasts 1 cycle.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// UART transmit engine: byte FIFO feeding a start/data/parity/stop serializer.
// Frame configuration is latched per frame; TXD and status outputs are registered.
module uart_tx_serializer #(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [7:0]                   DATA_IN,
  input  logic                         DATA_STROBE,
  output logic                         FULL,
  output logic                         EMPTY,
  output logic [$clog2(FIFO_DEPTH):0]  LEVEL,
  output logic                         OVERRUN,
  input  logic [15:0]                  DIVISOR,
  input  logic [1:0]                   WLEN,
  input  logic                         PEN,
  input  logic                         EPS,
  input  logic                         SPS,
  input  logic                         STP2,
  input  logic                         BRK,
  input  logic                         TXE,
  input  logic                         CTSEN,
  input  logic                         CTS,
  output logic                         TXD,
  output logic                         BUSY
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d, overrun_q, overrun_d;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, div_q, div_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic          stop_idx_q, stop_idx_d;
  logic [DW-1:0] shift_q, shift_d;
  logic [1:0]    wlen_q, wlen_d;
  logic          pen_q, pen_d, stp2_q, stp2_d, par_q, par_d;
  logic          txd_q, txd_d, busy_q, busy_d;

  logic          start_c, push_c, load_c, bit_end_c, data_par_c;
  logic [CW-1:0] div_eff_c;
  logic [DW-1:0] head_c, mask_c;

  assign start_c    = !empty_q && TXE && (!CTSEN || CTS);
  assign push_c     = DATA_STROBE && !full_q;
  assign bit_end_c  = (cnt_q == '0);
  assign div_eff_c  = (DIVISOR == '0) ? CW'(1) : DIVISOR;
  assign head_c     = mem_q[rd_ptr_q];
  assign mask_c     = 8'hFF >> (3'd3 - 3'(WLEN));
  assign data_par_c = ^(head_c & mask_c);

  // Next-state, FIFO bookkeeping and registered outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    wlen_d     = wlen_q;
    pen_d      = pen_q;
    stp2_d     = stp2_q;
    par_d      = par_q;
    div_d      = div_q;
    load_c     = 1'b0;

    if (state_q != IDLE) begin
      cnt_d = bit_end_c ? CW'(div_q - CW'(1)) : CW'(cnt_q - CW'(1));
    end

    case (state_q)
      IDLE: begin
        if (start_c) load_c = 1'b1;
      end
      START: begin
        if (bit_end_c) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (bit_end_c) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'(3'(wlen_q) + 3'd4)) begin
            state_d    = pen_q ? PARITY : STOP;
            stop_idx_d = 1'b0;
          end else begin
            bit_idx_d = 3'(bit_idx_q + 3'd1);
          end
        end
      end
      PARITY: begin
        if (bit_end_c) begin
          state_d    = STOP;
          stop_idx_d = 1'b0;
        end
      end
      STOP: begin
        if (bit_end_c) begin
          if (stp2_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else if (start_c) begin
            load_c = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame launch: pop head byte and snapshot configuration
    if (load_c) begin
      state_d = START;
      shift_d = head_c;
      wlen_d  = WLEN;
      pen_d   = PEN;
      stp2_d  = STP2;
      par_d   = SPS ? ~EPS : (EPS ? data_par_c : ~data_par_c);
      div_d   = div_eff_c;
      cnt_d   = CW'(div_eff_c - CW'(1));
    end

    wr_ptr_d = push_c ? AW'(wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = load_c ? AW'(rd_ptr_q + AW'(1)) : rd_ptr_q;
    case ({push_c, load_c})
      2'b10:   count_d = LW'(count_q + LW'(1));
      2'b01:   count_d = LW'(count_q - LW'(1));
      default: count_d = count_q;
    endcase
    full_d    = (count_d == LW'(FIFO_DEPTH));
    empty_d   = (count_d == '0);
    overrun_d = DATA_STROBE && full_q;

    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      PARITY:  txd_d = par_d;
      default: txd_d = 1'b1;
    endcase
    if (BRK) txd_d = 1'b0;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overrun_q  <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= CW'(1);
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      wlen_q     <= '0;
      pen_q      <= 1'b0;
      stp2_q     <= 1'b0;
      par_q      <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overrun_q  <= overrun_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      wlen_q     <= wlen_d;
      pen_q      <= pen_d;
      stp2_q     <= stp2_d;
      par_q      <= par_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
    end
  end

  // Storage array carries no reset; occupancy tracking makes stale entries invisible
  always_ff @(posedge CLK) begin
    if (push_c) mem_q[wr_ptr_q] <= DATA_IN;
  end

  assign FULL    = full_q;
  assign EMPTY   = empty_q;
  assign LEVEL   = count_q;
  assign OVERRUN = overrun_q;
  assign TXD     = txd_q;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: frame shape, parity, FIFO overrun/drain,
// CTS flow control, break and mid-frame reset, with hand-computed expectations.
module tb_uart_tx_serializer;

  logic        CLK = 1'b0;
  logic        RST, DATA_STROBE, FULL, EMPTY, OVERRUN;
  logic [7:0]  DATA_IN;
  logic [4:0]  LEVEL;
  logic [15:0] DIVISOR;
  logic [1:0]  WLEN;
  logic        PEN, EPS, SPS, STP2, BRK, TXE, CTSEN, CTS, TXD, BUSY;

  int vectors = 0;
  int miscompares = 0;

  uart_tx_serializer #(.FIFO_DEPTH(16)) dut (
    .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .DATA_STROBE(DATA_STROBE),
    .FULL(FULL), .EMPTY(EMPTY), .LEVEL(LEVEL), .OVERRUN(OVERRUN),
    .DIVISOR(DIVISOR), .WLEN(WLEN), .PEN(PEN), .EPS(EPS), .SPS(SPS),
    .STP2(STP2), .BRK(BRK), .TXE(TXE), .CTSEN(CTSEN), .CTS(CTS),
    .TXD(TXD), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Advance one cycle; inputs driven and outputs sampled 1 time unit after the edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called in cycle 0; returns in cycle 2 (start-bit cycle of an idle, enabled block)
  task automatic strobe_and_check(input logic [7:0] b, input string tag);
    DATA_IN = b;
    DATA_STROBE = 1'b1;
    tick();
    DATA_STROBE = 1'b0;
    chk({tag, "_level1"}, 32'(LEVEL), 32'd1);
    chk({tag, "_empty0"}, 32'(EMPTY), 32'd0);
    tick();
    chk({tag, "_level0"}, 32'(LEVEL), 32'd0);
  endtask

  // Called in the first cycle of a start bit; returns in the cycle after the last stop cycle
  task automatic check_frame(input logic [7:0] data, input int nbits, input bit pen,
                             input bit par, input int nstop, input int d,
                             input bit last, input string tag);
    logic [15:0] bits;
    int n;
    bits = '0;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < nbits; i++) begin
      bits[n] = data[i]; n++;
    end
    if (pen) begin
      bits[n] = par; n++;
    end
    for (int i = 0; i < nstop; i++) begin
      bits[n] = 1'b1; n++;
    end
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < d; c++) begin
        chk({tag, "_txd"}, 32'(TXD), 32'(bits[i]));
        chk({tag, "_busy"}, 32'(BUSY), 32'd1);
        tick();
      end
    end
    if (last) begin
      chk({tag, "_end_busy"}, 32'(BUSY), 32'd0);
      chk({tag, "_end_txd"}, 32'(TXD), 32'd1);
    end
  endtask

  initial begin
    RST = 1'b1; DATA_IN = '0; DATA_STROBE = 1'b0;
    DIVISOR = 16'd4; WLEN = 2'd3; PEN = 1'b0; EPS = 1'b0; SPS = 1'b0;
    STP2 = 1'b0; BRK = 1'b0; TXE = 1'b1; CTSEN = 1'b0; CTS = 1'b0;
    tick();
    tick();
    chk("rst_txd", 32'(TXD), 32'd1);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_full", 32'(FULL), 32'd0);
    chk("rst_empty", 32'(EMPTY), 32'd1);
    chk("rst_level", 32'(LEVEL), 32'd0);
    chk("rst_overrun", 32'(OVERRUN), 32'd0);
    RST = 1'b0;
    tick();

    // 8N1, divisor 4, 0x55: start 2-5, data 6-37, stop 38-41, idle at 42
    strobe_and_check(8'h55, "f55");
    check_frame(8'h55, 8, 1'b0, 1'b0, 1, 4, 1'b1, "f55");

    // 7 bits + parity, divisor 2, 0x41 (two ones)
    DIVISOR = 16'd2; WLEN = 2'd2; PEN = 1'b1; EPS = 1'b1;
    strobe_and_check(8'h41, "par_even");
    check_frame(8'h41, 7, 1'b1, 1'b0, 1, 2, 1'b1, "par_even");
    EPS = 1'b0;
    strobe_and_check(8'h41, "par_odd");
    check_frame(8'h41, 7, 1'b1, 1'b1, 1, 2, 1'b1, "par_odd");
    SPS = 1'b1; EPS = 1'b1; STP2 = 1'b1;
    strobe_and_check(8'h41, "par_stick");
    check_frame(8'h41, 7, 1'b1, 1'b0, 2, 2, 1'b1, "par_stick");
    SPS = 1'b0; EPS = 1'b0; STP2 = 1'b0; PEN = 1'b0; WLEN = 2'd3;

    // Overrun: fill 16, 17th strobe dropped
    TXE = 1'b0;
    for (int i = 0; i < 17; i++) begin
      chk("ovr_quiet", 32'(OVERRUN), 32'd0);
      DATA_IN = 8'(i);
      DATA_STROBE = 1'b1;
      tick();
    end
    DATA_STROBE = 1'b0;
    chk("ovr_pulse", 32'(OVERRUN), 32'd1);
    chk("ovr_level", 32'(LEVEL), 32'd16);
    chk("ovr_full", 32'(FULL), 32'd1);
    chk("ovr_busy", 32'(BUSY), 32'd0);
    tick();
    chk("ovr_once", 32'(OVERRUN), 32'd0);
    chk("ovr_txd_idle", 32'(TXD), 32'd1);
    TXE = 1'b1;
    tick();
    for (int f = 0; f < 16; f++) begin
      check_frame(8'(f), 8, 1'b0, 1'b0, 1, 2, (f == 15), "drain");
    end
    chk("drain_empty", 32'(EMPTY), 32'd1);
    chk("drain_level", 32'(LEVEL), 32'd0);

    // CTS flow control
    DIVISOR = 16'd4; CTSEN = 1'b1; CTS = 1'b0;
    DATA_IN = 8'hA5;
    DATA_STROBE = 1'b1;
    tick();
    DATA_STROBE = 1'b0;
    chk("cts_level", 32'(LEVEL), 32'd1);
    for (int i = 0; i < 100; i++) begin
      chk("cts_hold_txd", 32'(TXD), 32'd1);
      chk("cts_hold_busy", 32'(BUSY), 32'd0);
      tick();
    end
    CTS = 1'b1;
    tick();
    CTS = 1'b0;
    check_frame(8'hA5, 8, 1'b0, 1'b0, 1, 4, 1'b1, "cts_frame");
    CTSEN = 1'b0;

    // Break mid-frame: line forced low, frame timing unchanged
    strobe_and_check(8'h55, "brk");
    for (int i = 2; i < 10; i++) begin
      chk("brk_pre_txd", 32'(TXD), (i < 6) ? 32'd0 : 32'd1);
      tick();
    end
    BRK = 1'b1;
    tick();
    for (int i = 11; i < 42; i++) begin
      chk("brk_txd", 32'(TXD), 32'd0);
      chk("brk_busy", 32'(BUSY), 32'd1);
      tick();
    end
    chk("brk_end_busy", 32'(BUSY), 32'd0);
    chk("brk_end_txd", 32'(TXD), 32'd0);
    BRK = 1'b0;
    tick();
    chk("brk_release", 32'(TXD), 32'd1);

    // Reset mid-frame with three bytes queued
    for (int i = 0; i < 4; i++) begin
      DATA_IN = 8'(8'h11 * (i + 1));
      DATA_STROBE = 1'b1;
      tick();
    end
    DATA_STROBE = 1'b0;
    tick();
    tick();
    chk("mrst_pre_level", 32'(LEVEL), 32'd3);
    chk("mrst_pre_busy", 32'(BUSY), 32'd1);
    RST = 1'b1;
    tick();
    chk("mrst_txd", 32'(TXD), 32'd1);
    chk("mrst_busy", 32'(BUSY), 32'd0);
    chk("mrst_level", 32'(LEVEL), 32'd0);
    chk("mrst_empty", 32'(EMPTY), 32'd1);
    RST = 1'b0;
    tick();
    chk("mrst_stay_idle", 32'(BUSY), 32'd0);

    // Divisor 0 behaves as 1
    DIVISOR = 16'd0;
    strobe_and_check(8'h3C, "div0");
    check_frame(8'h3C, 8, 1'b0, 1'b0, 1, 1, 1'b1, "div0");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
